// File: rtl/univ_shift_reg_if.sv
// Data/control bundle for univ_shift_reg: operation select, parallel and serial
// inputs, register contents, serial outputs and shift-count status.
interface univ_shift_reg_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned CW = $clog2(WIDTH);

  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] q;
  logic             sout_l;
  logic             sout_r;
  logic [CW-1:0]    cnt;
  logic             done;

  modport master (
    output mode, d, sin_l, sin_r,
    input  q, sout_l, sout_r, cnt, done
  );

  modport slave (
    input  mode, d, sin_l, sin_r,
    output q, sout_l, sout_r, cnt, done
  );
endinterface

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register (hold/load/shift/rotate/ashr/clear) with a
// shift counter that pulses done for one cycle after every WIDTH shifts.
module univ_shift_reg #(
  parameter int unsigned     WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic            clk,
  input logic            res,
  univ_shift_reg_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_LOAD  = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_SHR   = 3'b011,
    MODE_ROL   = 3'b100,
    MODE_ROR   = 3'b101,
    MODE_ASHR  = 3'b110,
    MODE_CLEAR = 3'b111
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shift_c;
  mode_e            mode_c;

  assign mode_c = mode_e'(bus.mode);

  // Next-state data path and shift-count bookkeeping.
  always_comb begin
    q_d     = q_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    shift_c = 1'b0;
    unique case (mode_c)
      MODE_HOLD: ;
      MODE_LOAD: begin
        q_d   = bus.d;
        cnt_d = '0;
      end
      MODE_SHL: begin
        q_d     = {q_q[WIDTH-2:0], bus.sin_r};
        shift_c = 1'b1;
      end
      MODE_SHR: begin
        q_d     = {bus.sin_l, q_q[WIDTH-1:1]};
        shift_c = 1'b1;
      end
      MODE_ROL: begin
        q_d     = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        shift_c = 1'b1;
      end
      MODE_ROR: begin
        q_d     = {q_q[0], q_q[WIDTH-1:1]};
        shift_c = 1'b1;
      end
      MODE_ASHR: begin
        q_d     = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        shift_c = 1'b1;
      end
      MODE_CLEAR: begin
        q_d   = '0;
        cnt_d = '0;
      end
      default: ;
    endcase
    // Explicit compare so non-power-of-two widths wrap at WIDTH-1 too.
    if (shift_c) begin
      if (cnt_q == CW'(WIDTH - 1)) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      q_q    <= RST_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign bus.q      = q_q;
  assign bus.cnt    = cnt_q;
  assign bus.done   = done_q;
  assign bus.sout_l = q_q[WIDTH-1];
  assign bus.sout_r = q_q[0];
endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg (WIDTH=8, RST_VAL=8'h3C).
module tb_univ_shift_reg;
  logic clk = 1'b0;
  logic res;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  univ_shift_reg_if #(.WIDTH(8)) bus ();

  univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h3C)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [2:0] m, input logic [7:0] dv);
    bus.mode = m;
    bus.d    = dv;
    step();
  endtask

  task automatic test_reset();
    res = 1'b0;
    bus.mode = 3'b010; bus.d = 8'h00; bus.sin_l = 1'b1; bus.sin_r = 1'b1;
    step(); step();
    checks++; if (bus.q !== 8'h3C) begin failures++; $display("FAIL reset_q got=%h exp=3c", bus.q); end
    checks++; if (bus.cnt !== 3'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", bus.cnt); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.sout_l !== 1'b0) begin failures++; $display("FAIL reset_sout_l got=%b exp=0", bus.sout_l); end
    checks++; if (bus.sout_r !== 1'b0) begin failures++; $display("FAIL reset_sout_r got=%b exp=0", bus.sout_r); end
    res = 1'b1;
  endtask

  task automatic test_modes();
    logic [2:0] modes [6] = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b111, 3'b000};
    logic [7:0] expq  [6] = '{8'h4A, 8'hD2, 8'h4B, 8'hD2, 8'h00, 8'hA5};
    logic [2:0] expc  [6] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0};
    bus.sin_r = 1'b0; bus.sin_l = 1'b1;
    for (int i = 0; i < 6; i++) begin
      op(3'b001, 8'hA5);
      checks++; if (bus.q !== 8'hA5) begin failures++; $display("FAIL load_q[%0d] got=%h exp=a5", i, bus.q); end
      op(modes[i], 8'h00);
      checks++; if (bus.q !== expq[i]) begin failures++; $display("FAIL mode%0b_q got=%h exp=%h", modes[i], bus.q, expq[i]); end
      checks++; if (bus.cnt !== expc[i]) begin failures++; $display("FAIL mode%0b_cnt got=%0d exp=%0d", modes[i], bus.cnt, expc[i]); end
    end
  endtask

  task automatic test_ashr();
    op(3'b001, 8'h85);
    op(3'b110, 8'h00);
    checks++; if (bus.q !== 8'hC2 || bus.cnt !== 3'd1) begin failures++; $display("FAIL ashr1 got=%h/%0d exp=c2/1", bus.q, bus.cnt); end
    op(3'b110, 8'h00);
    checks++; if (bus.q !== 8'hE1 || bus.cnt !== 3'd2) begin failures++; $display("FAIL ashr2 got=%h/%0d exp=e1/2", bus.q, bus.cnt); end
  endtask

  task automatic test_wrap();
    op(3'b001, 8'hA5);
    for (int i = 1; i <= 7; i++) begin
      op(3'b100, 8'h00);
      checks++; if (bus.done !== 1'b0 || bus.cnt !== 3'(i)) begin failures++; $display("FAIL wrap_pre%0d got=%b/%0d exp=0/%0d", i, bus.done, bus.cnt, i); end
    end
    op(3'b100, 8'h00);
    checks++; if (bus.q !== 8'hA5 || bus.cnt !== 3'd0 || bus.done !== 1'b1) begin failures++; $display("FAIL wrap8 got=%h/%0d/%b exp=a5/0/1", bus.q, bus.cnt, bus.done); end
    op(3'b100, 8'h00);
    checks++; if (bus.q !== 8'h4B || bus.cnt !== 3'd1 || bus.done !== 1'b0) begin failures++; $display("FAIL wrap9 got=%h/%0d/%b exp=4b/1/0", bus.q, bus.cnt, bus.done); end
  endtask

  task automatic test_hold_gap();
    op(3'b001, 8'hA5);
    for (int i = 0; i < 4; i++) op(3'b100, 8'h00);
    op(3'b000, 8'h00);
    op(3'b000, 8'h00);
    checks++; if (bus.cnt !== 3'd4 || bus.done !== 1'b0 || bus.q !== 8'h5A) begin failures++; $display("FAIL hold_gap got=%h/%0d/%b exp=5a/4/0", bus.q, bus.cnt, bus.done); end
    for (int i = 0; i < 3; i++) op(3'b100, 8'h00);
    checks++; if (bus.done !== 1'b0 || bus.cnt !== 3'd7) begin failures++; $display("FAIL hold_gap7 got=%b/%0d exp=0/7", bus.done, bus.cnt); end
    op(3'b100, 8'h00);
    checks++; if (bus.done !== 1'b1 || bus.cnt !== 3'd0 || bus.q !== 8'hA5) begin failures++; $display("FAIL hold_gap8 got=%h/%0d/%b exp=a5/0/1", bus.q, bus.cnt, bus.done); end
    op(3'b000, 8'h00);
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL done_width got=%b exp=0", bus.done); end
  endtask

  task automatic test_reset_mid();
    bus.sin_r = 1'b1;
    op(3'b001, 8'h00);
    for (int i = 0; i < 7; i++) op(3'b010, 8'h00);
    checks++; if (bus.q !== 8'h7F || bus.cnt !== 3'd7) begin failures++; $display("FAIL pre_reset got=%h/%0d exp=7f/7", bus.q, bus.cnt); end
    res = 1'b0;
    op(3'b010, 8'h00);
    checks++; if (bus.q !== 8'h3C || bus.cnt !== 3'd0 || bus.done !== 1'b0) begin failures++; $display("FAIL mid_reset got=%h/%0d/%b exp=3c/0/0", bus.q, bus.cnt, bus.done); end
    res = 1'b1;
    for (int i = 0; i < 7; i++) op(3'b010, 8'h00);
    checks++; if (bus.done !== 1'b0 || bus.cnt !== 3'd7 || bus.q !== 8'h7F) begin failures++; $display("FAIL post_reset7 got=%h/%0d/%b exp=7f/7/0", bus.q, bus.cnt, bus.done); end
    op(3'b010, 8'h00);
    checks++; if (bus.done !== 1'b1 || bus.cnt !== 3'd0 || bus.q !== 8'hFF) begin failures++; $display("FAIL post_reset8 got=%h/%0d/%b exp=ff/0/1", bus.q, bus.cnt, bus.done); end
  endtask

  task automatic test_serial();
    logic [7:0] bits  = 8'b1011_0010;
    logic [7:0] expq [8] = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h16, 8'h2C, 8'h59, 8'hB2};
    logic       out_bit;
    op(3'b111, 8'h00);
    checks++; if (bus.q !== 8'h00 || bus.cnt !== 3'd0) begin failures++; $display("FAIL clear got=%h/%0d exp=00/0", bus.q, bus.cnt); end
    for (int i = 0; i < 8; i++) begin
      bus.sin_r = bits[7-i];
      op(3'b010, 8'h00);
      checks++; if (bus.q !== expq[i] || bus.sout_r !== bits[7-i]) begin failures++; $display("FAIL ser_in%0d got=%h/%b exp=%h/%b", i, bus.q, bus.sout_r, expq[i], bits[7-i]); end
    end
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL ser_done got=%b exp=1", bus.done); end
    bus.sin_r = 1'b0;
    for (int i = 0; i < 8; i++) begin
      out_bit = bus.sout_l;
      checks++; if (out_bit !== bits[7-i]) begin failures++; $display("FAIL ser_out%0d got=%b exp=%b", i, out_bit, bits[7-i]); end
      op(3'b010, 8'h00);
    end
    checks++; if (bus.q !== 8'h00) begin failures++; $display("FAIL ser_drain got=%h exp=00", bus.q); end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_ashr();
    test_wrap();
    test_hold_gap();
    test_reset_mid();
    test_serial();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register that generalises the single-bit reset flip-flop into a WIDTH-bit storage element. It supports hold, parallel load, logical shift, rotate, arithmetic shift and clear, and counts shift operations with a one-cycle done pulse after every WIDTH shifts. It is a building block for serialisers, deserialisers and bit-serial datapaths, and is always clocked by the single system clock.

## Interface
- WIDTH, default 8: register width in bits; legal range 2 to 64.
- RST_VAL, default 0: WIDTH-bit value loaded into q on reset.
- CW, derived as $clog2(WIDTH): width of cnt; not overridable.

- clk  in  1  system clock; all state updates on rising edge.
- res  in  1  one clock; reset is synchronous and active-low (res=0 sampled at a rising clk edge resets the block).
- mode  in  3  operation select for the current cycle; see Operation.
- d  in  WIDTH  parallel load data.
- sin_l  in  1  serial input entering at the MSB on right shifts.
- sin_r  in  1  serial input entering at the LSB on left shifts.
- q  out  WIDTH  register contents.
- sout_l  out  1  combinational copy of q[WIDTH-1].
- sout_r  out  1  combinational copy of q[0].
- cnt  out  CW  shift operations since the last load, clear, reset or wrap; range 0..WIDTH-1.
- done  out  1  registered pulse; high for exactly one cycle after the shift that completes WIDTH shifts.

## Operation
- Priority: res=0 overrides mode.
- Reset (res=0): q=RST_VAL, cnt=0, done=0.
- mode 000, hold: q, cnt unchanged; done=0.
- mode 001, load: q=d; cnt=0; done=0.
- mode 010, shift left: q={q[WIDTH-2:0], sin_r}.
- mode 011, shift right: q={sin_l, q[WIDTH-1:1]}.
- mode 100, rotate left: q={q[WIDTH-2:0], q[WIDTH-1]}.
- mode 101, rotate right: q={q[0], q[WIDTH-1:1]}.
- mode 110, arithmetic shift right: q={q[WIDTH-1], q[WIDTH-1:1]}.
- mode 111, clear: q=0, not RST_VAL; cnt=0; done=0.
- Counter update for modes 010-110 (shift class):
  - if cnt==WIDTH-1: cnt=0 and done=1;
  - else: cnt=cnt+1 and done=0.
- cnt never reaches WIDTH.
- Counter arithmetic is unsigned, CW bits. When WIDTH is a power of two, the wrap coincides with natural overflow; it is still implemented as an explicit compare.
- done is 0 on every cycle that is not a counted wrap. Back-to-back wraps are only possible when WIDTH shifts separate them.

## Timing
- Latency: q, cnt and done reflect the mode and inputs sampled at edge N immediately after edge N; registered, one cycle.
- sout_l and sout_r follow q combinationally with no extra latency.
- Reset mid-operation: res=0 at any edge, including the wrapping shift, forces reset values at that edge. A pending done is suppressed.
- Reset release: the first edge with res=1 executes mode normally.
- mode, d, sin_l and sin_r must be stable around the rising clk edge. There is no handshake; every edge executes one operation.
- Load or clear during a partially counted sequence discards the count. The next shift sets cnt=1.

## Test plan
- Reset: res=0 for 2 edges with mode=010 and RST_VAL=8'h3C -> q=8'h3C, cnt=0, done=0, sout_l=0, sout_r=0.
- Modes: load 8'hA5, then separately apply each op from 8'hA5:
  - shift left with sin_r=0 -> 8'h4A;
  - shift right with sin_l=1 -> 8'hD2;
  - rotate left -> 8'h4B;
  - rotate right -> 8'hD2;
  - clear -> 8'h00.
- Arithmetic shift: load 8'h85, apply mode 110 twice -> 8'hC2, then 8'hE1; cnt goes 1, 2.
- Wrap counter: load 8'hA5, then 8 rotate lefts -> q=8'hA5, cnt=0, done=1 for exactly the cycle after the 8th edge.
  - A 9th rotate -> done=0, cnt=1.
  - Inserting 2 hold cycles mid-sequence delays done by 2 cycles.
- Reset mid-operation: 7 shifts, then res=0 on the 8th shift edge -> q=RST_VAL, cnt=0, done stays 0. After release, 8 more shifts are needed for done.
- Serial I/O: 8 shift-lefts feeding sin_r with 1,0,1,1,0,0,1,0 from 8'h00 -> q=8'hB2; sout_l sequence matches the bits shifted out.
